// File: rtl/inside_pkg.sv
// Shared definitions for the circle-inclusion check and the vote stage.
package inside_pkg;

  typedef enum logic {ACC, HOLD} state_t;

  localparam int K_DEF  = 4;
  localparam int CW_DEF = 8;

  // Width needed to hold a vote count of 0..k
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/vote_sat_cnt.sv
// Saturating up-counter with synchronous clear; cnt_nxt exposes the value after
// the current increment so the closing beat can use it in the same cycle.
module vote_sat_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign cnt_nxt = (inc && (cnt != MAX_V)) ? cnt + W'(1) : cnt;

  // Count register; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt_nxt;
  end

endmodule

// File: rtl/inside_vote.sv
// Vote stage after the circle-inclusion check: counts in-range anchors per
// candidate, tracks the best candidate over a frame and holds the decision
// until consumed. Optional macro INSIDE_VOTE_THRESH_EN adds a min_votes port
// and qualifies res_found against it instead of against zero.
module inside_vote
  import inside_pkg::*;
#(
  parameter  int K     = K_DEF,
  parameter  int CW    = CW_DEF,
  localparam int CNT_W = cnt_w(K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             outside,
  input  logic             anchor_last,
  input  logic             cand_last,
`ifdef INSIDE_VOTE_THRESH_EN
  input  logic [CNT_W-1:0] min_votes,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CW-1:0]    res_idx,
  output logic [CNT_W-1:0] res_cnt,
  output logic             res_found
);

  state_t           state, state_d;
  logic [CW-1:0]    cand_idx, best_idx, best_idx_d;
  logic [CNT_W-1:0] cur_cnt, cnt_f, best_cnt, best_cnt_d;
  logic             first_cand;
  logic             beat, close, done, hs, take, found_d;

  assign in_ready  = (state == ACC);
  assign res_valid = (state == HOLD);
  assign beat      = in_valid & in_ready;
  assign close     = beat & anchor_last;
  assign done      = close & cand_last;
  assign hs        = res_valid & res_ready;

  vote_sat_cnt #(.MAX(K), .W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (close | hs),
    .en      (beat),
    .inc     (~outside),
    .cnt     (cur_cnt),
    .cnt_nxt (cnt_f)
  );

  // Best candidate after this closing beat; strict > keeps the earliest on ties.
  // A dedicated first-candidate flag keeps this correct across index wrap.
  always_comb begin
    take       = first_cand | (cnt_f > best_cnt);
    best_idx_d = take ? cand_idx : best_idx;
    best_cnt_d = take ? cnt_f    : best_cnt;
`ifdef INSIDE_VOTE_THRESH_EN
    found_d    = (best_cnt_d >= min_votes);
`else
    found_d    = (best_cnt_d != '0);
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ACC:     if (done) state_d = HOLD;
      HOLD:    if (hs)   state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_d;
  end

  // Frame tracking: candidate index, best-so-far, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_idx   <= '0;
      best_idx   <= '0;
      best_cnt   <= '0;
      first_cand <= 1'b1;
      res_idx    <= '0;
      res_cnt    <= '0;
      res_found  <= 1'b0;
    end else if (hs) begin
      cand_idx   <= '0;
      best_idx   <= '0;
      best_cnt   <= '0;
      first_cand <= 1'b1;
    end else if (close) begin
      cand_idx   <= cand_idx + CW'(1);
      best_idx   <= best_idx_d;
      best_cnt   <= best_cnt_d;
      first_cand <= 1'b0;
      if (cand_last) begin
        res_idx   <= best_idx_d;
        res_cnt   <= best_cnt_d;
        res_found <= found_d;
      end
    end
  end

endmodule

// File: tb/tb_inside_vote.sv
// Directed bench for inside_vote (K=4, CW=8).
module tb_inside_vote;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, outside, anchor_last, cand_last;
  logic [2:0] min_votes;
  logic       res_valid, res_ready, res_found;
  logic [7:0] res_idx;
  logic [2:0] res_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inside_vote #(.K(4), .CW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .outside     (outside),
    .anchor_last (anchor_last),
    .cand_last   (cand_last),
`ifdef INSIDE_VOTE_THRESH_EN
    .min_votes   (min_votes),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_idx     (res_idx),
    .res_cnt     (res_cnt),
    .res_found   (res_found)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted beat; returns #1 after the capturing edge
  task automatic beat(input logic o, input logic al, input logic cl);
    in_valid = 1'b1; outside = o; anchor_last = al; cand_last = cl;
    @(posedge clk); #1;
    in_valid = 1'b0; anchor_last = 1'b0; cand_last = 1'b0; outside = 1'b0;
  endtask

  task automatic cand(input logic [3:0] ob, input int n, input logic cl);
    for (int i = 0; i < n; i++) beat(ob[i], i == n - 1, (i == n - 1) && cl);
  endtask

  task automatic chk_res(input string tag, input int idx, input int cnt, input logic found);
    chk({tag, ".valid"}, res_valid, 1);
    chk({tag, ".idx"},   res_idx,   idx);
    chk({tag, ".cnt"},   res_cnt,   cnt);
    chk({tag, ".found"}, res_found, found);
    chk({tag, ".rdy"},   in_ready,  0);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".vld0"}, res_valid, 0);
    chk({tag, ".rdy1"}, in_ready,  1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; outside = 1'b0; anchor_last = 1'b0;
    cand_last = 1'b0; res_ready = 1'b1; min_votes = 3'd3;
    #12;
    chk("rst.valid", res_valid, 0);
    chk("rst.ready", in_ready,  1);
    chk("rst.idx",   res_idx,   0);
    chk("rst.cnt",   res_cnt,   0);
    chk("rst.found", res_found, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: counts 2,3,0 -> best idx 1 (outside bits LSB = first beat)
    cand(4'b1100, 4, 1'b0);
    cand(4'b1000, 4, 1'b0);
    cand(4'b1111, 4, 1'b1);
    chk_res("t1", 1, 3, 1'b1);
    consume("t1");

    // 2: tie 2,2 -> earliest; idle cycles and cand_last without anchor_last ignored
    beat(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; outside = 1'b0; anchor_last = 1'b1; cand_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t2.idle", res_valid, 0);
    anchor_last = 1'b0; cand_last = 1'b0;
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    cand(4'b1001, 4, 1'b1);
    chk_res("t2", 0, 2, 1'b1);
    consume("t2");

    // 3: backpressure; counts 0,2 -> idx 1, held for 5 cycles
    res_ready = 1'b0;
    cand(4'b0011, 2, 1'b0);
    cand(4'b0000, 2, 1'b1);
    chk_res("t3", 1, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; anchor_last = 1'b1; cand_last = 1'b1;
      @(posedge clk); #1;
      chk("t3.hold.valid", res_valid, 1);
      chk("t3.hold.ready", in_ready,  0);
      chk("t3.hold.idx",   res_idx,   1);
      chk("t3.hold.cnt",   res_cnt,   2);
    end
    in_valid = 1'b0; anchor_last = 1'b0; cand_last = 1'b0;
    consume("t3");
    cand(4'b0000, 1, 1'b1);
    chk_res("t3.new", 0, 1, 1'b1);
    consume("t3.new");

    // 4: short candidate of 2 beats -> 2; 6 beats saturate at 4
    cand(4'b0000, 2, 1'b1);
    chk_res("t4.short", 0, 2, 1'b1);
    consume("t4.short");
    for (int i = 0; i < 6; i++) beat(1'b0, i == 5, i == 5);
    chk_res("t4.sat", 0, 4, 1'b1);
    consume("t4.sat");
    cand(4'b0000, 2, 1'b0);
    for (int i = 0; i < 6; i++) beat(1'b0, i == 5, i == 5);
    chk_res("t4.pair", 1, 4, 1'b1);
    consume("t4.pair");

    // 5: reset mid-frame after 2 beats
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    chk("t5.valid", res_valid, 0);
    chk("t5.ready", in_ready,  1);
    chk("t5.idx",   res_idx,   0);
    chk("t5.cnt",   res_cnt,   0);
    chk("t5.found", res_found, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    chk_res("t5.new", 0, 1, 1'b1);
    consume("t5.new");

    // 6: best count 2 vs threshold 3; all-outside frame
`ifdef INSIDE_VOTE_THRESH_EN
    cand(4'b1100, 4, 1'b1);
    chk_res("t6.thr", 0, 2, 1'b0);
`else
    cand(4'b1100, 4, 1'b1);
    chk_res("t6.thr", 0, 2, 1'b1);
`endif
    consume("t6.thr");
    cand(4'b1111, 4, 1'b0);
    cand(4'b1111, 4, 1'b1);
    chk_res("t6.none", 0, 0, 1'b0);
    consume("t6.none");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
